// File: rtl/if_id_stage_reg.sv
// ---------------------------------------------------------------------------
// if_id_stage_reg
//
// Purpose:
//   IF/ID pipeline register between fetch and decode. It uses a valid/ready
//   handshake on both sides and supports decode stalls and a flush for
//   branch/jump redirects. Whenever the stage holds no valid beat, decode
//   sees NOP_INSTR. A saturating counter records how many valid entries were
//   killed by flushes.
//
// Configuration macro:
//   IF_ID_SKID_EN - when defined, the stage is a two-entry skid buffer
//                   (main + skid register). Its in_ready_o is registered,
//                   so there is no combinational path from out_ready_i.
//                   When undefined, the stage is a single entry. Its
//                   in_ready_o is combinational.
//
// Parameters:
//   PC_W      - width of the PC payload
//   INSTR_W   - width of the instruction payload
//   NOP_INSTR - instruction presented while the stage is empty or flushed
//   CNT_W     - width of the saturating flush counter (must be >= 2)
//
// Ports:
//   clk_i        in   clock; all state changes on the rising edge
//   rst_i        in   synchronous reset, active-low
//   flush_i      in   kill the stage contents
//   in_valid_i   in   fetch presents a beat
//   in_ready_o   out  stage can accept a beat this cycle
//   pc_i         in   fetched PC
//   instr_i      in   fetched instruction
//   out_valid_o  out  decode-side beat valid
//   out_ready_i  in   decode accepts the beat (0 = decode stall)
//   pc_o         out  held PC
//   instr_o      out  held instruction, NOP_INSTR when out_valid_o=0
//   flush_cnt_o  out  valid entries killed by flush, saturating
// ---------------------------------------------------------------------------
module if_id_stage_reg #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [CNT_W-1:0]   flush_cnt_o
);

  // Handshake events on both sides of the stage
  logic accept;
  logic drain;

  // Main (decode-facing) entry
  logic [PC_W-1:0]    mainPc_q,    mainPc_d;
  logic [INSTR_W-1:0] mainInstr_q, mainInstr_d;

  // Flush bookkeeping
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
  logic [1:0]       killCount;
  logic [CNT_W:0]   cntSum;

  assign accept = in_valid_i & in_ready_o;
  assign drain  = out_valid_o & out_ready_i;

  assign pc_o        = mainPc_q;
  assign instr_o     = mainInstr_q;
  assign flush_cnt_o = flushCnt_q;

`ifdef IF_ID_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Skid entry, which is always older than any beat still on the input
  logic [PC_W-1:0]    skidPc_q,    skidPc_d;
  logic [INSTR_W-1:0] skidInstr_q, skidInstr_d;

  // Ready depends only on registered state. The skid entry is occupied
  // exactly in state TWO.
  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);

  always_comb begin
    killCount = 2'd0;
    case (state_q)
      ONE:     killCount = 2'd1;
      TWO:     killCount = 2'd2;
      default: killCount = 2'd0;
    endcase
  end

  // Next-state and datapath for the two-entry buffer. Flush wins over any
  // handshake. When the main entry empties, it is loaded with NOP_INSTR so
  // that instr_o needs no output mux.
  always_comb begin
    state_d     = state_q;
    mainPc_d    = mainPc_q;
    mainInstr_d = mainInstr_q;
    skidPc_d    = skidPc_q;
    skidInstr_d = skidInstr_q;
    if (flush_i) begin
      state_d     = EMPTY;
      mainInstr_d = NOP_INSTR;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            mainPc_d    = pc_i;
            mainInstr_d = instr_i;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            state_d     = TWO;
            skidPc_d    = pc_i;
            skidInstr_d = instr_i;
          end else if (accept && drain) begin
            mainPc_d    = pc_i;
            mainInstr_d = instr_i;
          end else if (drain) begin
            state_d     = EMPTY;
            mainInstr_d = NOP_INSTR;
          end
        end
        TWO: begin
          if (drain) begin
            state_d     = ONE;
            mainPc_d    = skidPc_q;
            mainInstr_d = skidInstr_q;
          end
        end
        default: begin
          state_d     = EMPTY;
          mainInstr_d = NOP_INSTR;
        end
      endcase
    end
  end

  // Skid register, which only exists in this configuration
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      skidPc_q    <= '0;
      skidInstr_q <= NOP_INSTR;
    end else begin
      skidPc_q    <= skidPc_d;
      skidInstr_q <= skidInstr_d;
    end
  end

`else

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // A full stage can still take a beat when decode drains it in the same
  // cycle or when a flush is discarding it.
  assign in_ready_o  = (state_q == EMPTY) | out_ready_i | flush_i;
  assign out_valid_o = (state_q == FULL);

  assign killCount = (state_q == FULL) ? 2'd1 : 2'd0;

  // Next-state and datapath for the single entry. Accept covers both the
  // empty-fill case and the replace-on-drain case.
  always_comb begin
    state_d     = state_q;
    mainPc_d    = mainPc_q;
    mainInstr_d = mainInstr_q;
    if (flush_i) begin
      state_d     = EMPTY;
      mainInstr_d = NOP_INSTR;
    end else if (accept) begin
      state_d     = FULL;
      mainPc_d    = pc_i;
      mainInstr_d = instr_i;
    end else if (drain) begin
      state_d     = EMPTY;
      mainInstr_d = NOP_INSTR;
    end
  end

`endif

  // Saturating flush counter. It adds the number of entries held at the
  // flush edge and clamps at all-ones instead of wrapping.
  assign cntSum = {1'b0, flushCnt_q} + {{(CNT_W - 1){1'b0}}, killCount};

  always_comb begin
    flushCnt_d = flushCnt_q;
    if (flush_i) begin
      flushCnt_d = cntSum[CNT_W] ? {CNT_W{1'b1}} : cntSum[CNT_W-1:0];
    end
  end

  // State, main entry and counter registers. Reset overrides flush and
  // handshakes.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= EMPTY;
      mainPc_q    <= '0;
      mainInstr_q <= NOP_INSTR;
      flushCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mainPc_q    <= mainPc_d;
      mainInstr_q <= mainInstr_d;
      flushCnt_q  <= flushCnt_d;
    end
  end

endmodule
